// File: rtl/neuron_accum.sv
// Neuron accumulator: sums N_TERMS signed products, adds a bias, rescales,
// optionally rectifies, and saturates to a signed activation.
module neuron_accum #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16,
    parameter int N_TERMS   = 4,
    parameter int BIAS      = 0,
    parameter int SHIFT     = 0,
    parameter bit RELU      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] BIAS_EXT = ACC_WIDTH'(BIAS);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // The accumulator must hold N_TERMS worst-case products plus the bias.
    generate
        if (ACC_WIDTH < IN_WIDTH + $clog2(N_TERMS) + 2 || ACC_WIDTH < OUT_WIDTH
            || N_TERMS < 1) begin : g_bad_params
            $error("neuron_accum: ACC_WIDTH too small or N_TERMS < 1");
        end
    endgenerate

    typedef enum logic {ACCUM = 1'b0, RESULT = 1'b1} state_t;

    state_t                        state, state_next;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [CW-1:0]                 count;
    logic signed [ACC_WIDTH-1:0]   in_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [ACC_WIDTH-1:0]   rect;
    logic signed [ACC_WIDTH-1:0]   clamped;
    logic                          clamp_hit;
    logic                          in_fire;
    logic                          out_fire;
    logic                          last_beat;

    // Handshake: a beat transfers on in_valid && in_ready, a result on
    // out_valid && out_ready; in_ready never depends on in_valid.
    assign in_ready  = (state == ACCUM) || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == RESULT);
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (count == CW'(N_TERMS - 1));
    assign busy      = (count != '0) || out_valid;

    assign in_ext  = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign sum     = acc + in_ext;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        rect      = shifted;
        clamped   = '0;
        clamp_hit = 1'b0;
        if (RELU && shifted < 0) begin
            rect = '0;
        end
        // ReLU zeroing happens before the clamp, so it never flags saturation.
        if (rect > OUT_MAX) begin
            clamped   = OUT_MAX;
            clamp_hit = 1'b1;
        end else if (rect < OUT_MIN) begin
            clamped   = OUT_MIN;
            clamp_hit = 1'b1;
        end else begin
            clamped = rect;
        end
    end

    always_comb begin
        state_next = state;
        if (in_fire && last_beat) begin
            state_next = RESULT;
        end else if (out_fire) begin
            state_next = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= BIAS_EXT;
            count    <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                if (last_beat) begin
                    acc      <= BIAS_EXT;
                    count    <= '0;
                    out_data <= clamped[OUT_WIDTH-1:0];
                    out_sat  <= clamp_hit;
                end else begin
                    acc   <= sum;
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_accum.sv
// Directed bench for neuron_accum: three configurations share one stimulus
// stream (A: RELU, bias 10; B: no RELU, bias 10; C: shift 2, bias 0, no RELU).
module tb_neuron_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
    logic [15:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
    logic [15:0] out_data_b;
    logic        in_ready_c, out_valid_c, out_sat_c, busy_c;
    logic [15:0] out_data_c;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_accum #(.N_TERMS(4), .BIAS(10), .SHIFT(0), .RELU(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_sat(out_sat_a), .busy(busy_a)
    );

    neuron_accum #(.N_TERMS(4), .BIAS(10), .SHIFT(0), .RELU(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_sat(out_sat_b), .busy(busy_b)
    );

    neuron_accum #(.N_TERMS(4), .BIAS(0), .SHIFT(2), .RELU(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_data(out_data_c), .out_sat(out_sat_c), .busy(busy_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int b0, b1, b2, b3;
        int exp_a; int sat_a;
        int exp_b; int sat_b;
        int exp_c; int sat_c;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one beat and wait until it has been accepted
    task automatic send_beat(input int v);
        int guard;
        in_valid = 1'b1;
        in_data  = v;
        guard    = 0;
        while (!in_ready_a && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("beat_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        out_ready = 1'b1;
        send_beat(vecs[i].b0);
        send_beat(vecs[i].b1);
        send_beat(vecs[i].b2);
        send_beat(vecs[i].b3);
        check($sformatf("v%0d_valid", i), int'(out_valid_a), 1);
        check($sformatf("v%0d_a_data", i), int'($signed(out_data_a)), vecs[i].exp_a);
        check($sformatf("v%0d_a_sat", i), int'(out_sat_a), vecs[i].sat_a);
        check($sformatf("v%0d_b_data", i), int'($signed(out_data_b)), vecs[i].exp_b);
        check($sformatf("v%0d_b_sat", i), int'(out_sat_b), vecs[i].sat_b);
        check($sformatf("v%0d_c_data", i), int'($signed(out_data_c)), vecs[i].exp_c);
        check($sformatf("v%0d_c_sat", i), int'(out_sat_c), vecs[i].sat_c);
        tick();
        check($sformatf("v%0d_valid_drop", i), int'(out_valid_a), 0);
        check($sformatf("v%0d_busy_idle", i), int'(busy_a), 0);
    endtask

    initial begin
        //           beats                         A           B             C
        vecs[0] = '{100, -20, 5, 7,              102, 0,     102, 0,       23, 0};
        vecs[1] = '{-50, -50, -50, -50,          0, 0,       -190, 0,      -50, 0};
        vecs[2] = '{20000, 20000, 20000, 20000,  32767, 1,   32767, 1,     20000, 0};
        vecs[3] = '{-20000, -20000, -20000, -20000, 0, 0,    -32768, 1,    -20000, 0};
        vecs[4] = '{-3, 0, 0, 0,                 7, 0,       7, 0,         -1, 0};
        vecs[5] = '{7, 0, 0, 0,                  17, 0,      17, 0,        1, 0};
        vecs[6] = '{200000, 200000, 200000, 200000, 32767, 1, 32767, 1,    32767, 1};
        vecs[7] = '{1, 2, 3, 4,                  20, 0,      20, 0,        2, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_data", int'(out_data_a), 0);
        check("rst_out_sat", int'(out_sat_a), 0);
        check("rst_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) apply_vec(i);

        // backpressure: hold the result, offered beats must not be taken
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_beat(1);
        check("bp_valid", int'(out_valid_a), 1);
        check("bp_data", int'($signed(out_data_a)), 14);
        in_valid = 1'b1;
        in_data  = 1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_stall%0d_in_ready", k), int'(in_ready_a), 0);
            check($sformatf("bp_stall%0d_data", k), int'($signed(out_data_a)), 14);
            check($sformatf("bp_stall%0d_valid", k), int'(out_valid_a), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", int'(in_ready_a), 1);
        // eight continuous beats of 1: results expected right after beats 4 and 8
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) in_valid = 1'b0;
            check($sformatf("stream%0d_valid", k), int'(out_valid_a),
                  (k == 3 || k == 7) ? 1 : 0);
            if (k == 3 || k == 7)
                check($sformatf("stream%0d_data", k), int'($signed(out_data_a)), 14);
            check($sformatf("stream%0d_in_ready", k), int'(in_ready_a), 1);
        end
        tick();
        check("stream_end_valid", int'(out_valid_a), 0);
        check("stream_end_busy", int'(busy_a), 0);

        // asynchronous reset in the middle of a partial sum
        send_beat(999);
        send_beat(999);
        check("pre_rst_busy", int'(busy_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid_a), 0);
        check("mid_rst_data", int'(out_data_a), 0);
        check("mid_rst_busy", int'(busy_a), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        apply_vec(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
